// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package if_prefetch_queue_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Jump keeps the region bits of the sequential PC; branch offsets are in words.
   function automatic logic [XLEN-1:0] redirect_target(
      input logic [XLEN-1:0] pc,
      input logic            jump,
      input logic [XLEN-1:0] branch_offset,
      input logic [25:0]     jump_address
   );
      logic [XLEN-1:0] pc_plus4;
      pc_plus4 = pc + XLEN'(4);
      if (jump) return {pc_plus4[31:28], jump_address, 2'b00};
      return pc_plus4 + {branch_offset[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/if_prefetch_queue_inst_fifo.sv
// Circular buffer of fetched {PC, instruction} pairs; flush wins over push/pop.
module if_prefetch_queue_inst_fifo
   import if_prefetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wdata,
   output fetch_entry_t           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: one-outstanding memory requests, prefetch queue, registered decode output.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Stall,
   input  logic [31:0] BranchOffset,
   input  logic [25:0] JumpAddress,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemReady,
   input  logic        MemValid,
   input  logic [31:0] MemData,
   output logic [31:0] Inst,
   output logic [31:0] InstPC,
   output logic        InstValid
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [31:0]      inst_pc_q, inst_pc_d;
   logic             inst_valid_q, inst_valid_d;
   logic             redirect_c, mem_req_c, push_c, pop_c;
   logic [31:0]      target_c;
   fetch_entry_t     head, push_entry;
   logic             q_full, q_empty;
   logic [CNT_W-1:0] q_count;

   always_comb begin
      redirect_c = (Branch | Jump) & inst_valid_q & ~Stall;
      target_c   = redirect_target(inst_pc_q, Jump, BranchOffset, JumpAddress);
      mem_req_c  = (state_q == ST_FETCH) && (q_count < CNT_W'(DEPTH)) && !redirect_c && !Reset;
      pop_c      = !redirect_c && !Stall && !q_empty;
      push_entry = '{pc: fetch_pc_q - 32'd4, inst: MemData};
   end

   // Memory FSM; FetchPC has already advanced past the outstanding word.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push_c     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (mem_req_c && MemReady) begin
               state_d    = ST_WAIT;
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         ST_WAIT: begin
            if (MemValid) begin
               state_d = ST_FETCH;
               push_c  = !redirect_c && (!q_full || pop_c);
            end else if (redirect_c) begin
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (MemValid) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
      if (redirect_c) fetch_pc_d = target_c;
   end

   always_comb begin
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      if (redirect_c) begin
         inst_d       = NOP;
         inst_valid_d = 1'b0;
      end else if (!Stall) begin
         if (!q_empty) begin
            inst_d       = head.inst;
            inst_pc_d    = head.pc;
            inst_valid_d = 1'b1;
         end else begin
            inst_d       = NOP;
            inst_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_FETCH;
         fetch_pc_q   <= RESET_PC;
         inst_q       <= NOP;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   if_prefetch_queue_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (Clk),
      .rst   (Reset),
      .push  (push_c),
      .pop   (pop_c),
      .flush (redirect_c),
      .wdata (push_entry),
      .rdata (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   assign MemReq    = mem_req_c;
   assign MemAddr   = fetch_pc_q;
   assign Inst      = inst_q;
   assign InstPC    = inst_pc_q;
   assign InstValid = inst_valid_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed vector table, corner sequences, random run vs. queue model.
module tb_if_prefetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Reset, Branch, Jump, Stall, MemReady, MemValid;
   logic [31:0] BranchOffset, MemData;
   logic [25:0] JumpAddress;
   logic        MemReq, InstValid;
   logic [31:0] MemAddr, Inst, InstPC;

   if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .Clk(Clk), .Reset(Reset), .Branch(Branch), .Jump(Jump), .Stall(Stall),
      .BranchOffset(BranchOffset), .JumpAddress(JumpAddress),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemReady(MemReady),
      .MemValid(MemValid), .MemData(MemData),
      .Inst(Inst), .InstPC(InstPC), .InstValid(InstValid)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory environment: single pending response with a countdown.
   bit          pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          lat_cnt = 0;
   int          fixed_lat = 1;
   bit          rand_lat = 1'b0;
   bit          spur_en = 1'b0;

   // Reference model: a plain queue of {pc, inst} plus outstanding-request flags.
   typedef struct packed { logic [31:0] pc; logic [31:0] inst; } m_ent_t;
   m_ent_t      mq[$];
   logic [31:0] m_fpc, m_req_pc, m_inst, m_pc;
   bit          m_out, m_drop, m_valid;

   typedef struct {
      bit          stall;
      bit          branch;
      logic [31:0] boff;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input bit s, input bit b, input logic [31:0] off,
                               input bit rq, input logic [31:0] ad,
                               input bit v, input logic [31:0] pc);
      vec_t r;
      r.stall = s; r.branch = b; r.boff = off;
      r.exp_req = rq; r.exp_addr = ad; r.exp_valid = v; r.exp_pc = pc;
      return r;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h2001_0005;
      return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc = 32'h0; m_req_pc = '0; m_inst = '0; m_pc = '0;
      m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
   endtask

   function automatic bit m_redir();
      return (Branch || Jump) && m_valid && !Stall;
   endfunction

   function automatic bit m_req();
      return !Reset && !m_out && (mq.size() < DEPTH) && !m_redir();
   endfunction

   task automatic check_model();
      bit rq;
      rq = m_req();
      chk("model valid", 32'(InstValid), 32'(m_valid));
      chk("model inst", Inst, m_inst);
      chk("model inst_pc", InstPC, m_pc);
      chk("model mem_req", 32'(MemReq), 32'(rq));
      if (rq) chk("model mem_addr", MemAddr, m_fpc);
   endtask

   task automatic model_step();
      bit          rd, rq;
      logic [31:0] pc4, tgt;
      m_ent_t      e;
      rd  = m_redir();
      rq  = m_req();
      pc4 = m_pc + 32'd4;
      tgt = Jump ? {pc4[31:28], JumpAddress, 2'b00} : pc4 + (BranchOffset << 2);
      if (rd) begin
         m_inst = 32'h0; m_valid = 1'b0;
      end else if (!Stall) begin
         if (mq.size() > 0) begin
            e = mq.pop_front();
            m_inst = e.inst; m_pc = e.pc; m_valid = 1'b1;
         end else begin
            m_inst = 32'h0; m_valid = 1'b0;
         end
      end
      if (m_out && MemValid) begin
         if (!m_drop && !rd) mq.push_back('{pc: m_req_pc, inst: MemData});
         m_out = 1'b0; m_drop = 1'b0;
      end else if (m_out && rd) begin
         m_drop = 1'b1;
      end
      if (rd) mq.delete();
      if (rq && MemReady) begin
         m_out = 1'b1; m_req_pc = m_fpc; m_fpc = m_fpc + 32'd4;
      end
      if (rd) m_fpc = tgt;
   endtask

   task automatic check_row(input int row);
      vec_t v;
      v = tbl[row];
      chk($sformatf("row%0d valid", row), 32'(InstValid), 32'(v.exp_valid));
      chk($sformatf("row%0d inst_pc", row), InstPC, v.exp_pc);
      chk($sformatf("row%0d inst", row), Inst, v.exp_valid ? mem_word(v.exp_pc) : 32'h0);
      chk($sformatf("row%0d mem_req", row), 32'(MemReq), 32'(v.exp_req));
      if (v.exp_req) chk($sformatf("row%0d mem_addr", row), MemAddr, v.exp_addr);
   endtask

   // One clock: check at negedge, advance model, then let memory respond after the edge.
   task automatic tick(input int row);
      bit          acc;
      logic [31:0] acc_addr;
      @(negedge Clk);
      if (Reset) model_reset();
      check_model();
      if (row >= 0) check_row(row);
      acc      = (MemReq === 1'b1) && MemReady;
      acc_addr = MemAddr;
      if (!Reset) model_step();
      @(posedge Clk);
      #1;
      MemValid = 1'b0;
      MemData  = $urandom;
      if (Reset) begin
         pend = 1'b0;
      end else begin
         if (acc) begin
            pend = 1'b1; pend_addr = acc_addr;
            lat_cnt = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
         end
         if (pend) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               MemValid = 1'b1; MemData = mem_word(pend_addr); pend = 1'b0;
            end
         end else if (spur_en && $urandom_range(0, 19) == 0) begin
            MemValid = 1'b1;
         end
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (InstValid !== 1'b1 && n < 60) begin tick(-1); n++; end
      chk({name, " valid seen"}, 32'(InstValid), 32'd1);
   endtask

   task automatic wait_req(input string name, input logic [31:0] addr);
      int n = 0;
      #1;
      while (MemReq !== 1'b1 && n < 60) begin tick(-1); #1; n++; end
      chk({name, " req seen"}, 32'(MemReq), 32'd1);
      chk({name, " req addr"}, MemAddr, addr);
   endtask

   task automatic branch_to(input logic [31:0] target);
      BranchOffset = (target - (m_pc + 32'd4)) >> 2;
      Branch = 1'b1;
      tick(-1);
      Branch = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      Reset = 1'b1; Branch = 1'b0; Jump = 1'b0; Stall = 1'b0;
      BranchOffset = '0; JumpAddress = '0; MemReady = 1'b1; MemValid = 1'b0; MemData = '0;
      model_reset();

      // Cycle-by-cycle expectations with a 1-cycle memory, from reset release.
      tbl.push_back(mk(0, 0, 32'h0,         1, 32'h00, 0, 32'h00));
      tbl.push_back(mk(0, 0, 32'h0,         0, 32'h00, 0, 32'h00));
      tbl.push_back(mk(0, 0, 32'h0,         1, 32'h04, 0, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         0, 32'h00, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         1, 32'h08, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         0, 32'h00, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         1, 32'h0C, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         0, 32'h00, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         1, 32'h10, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         0, 32'h00, 1, 32'h00));
      tbl.push_back(mk(1, 0, 32'h0,         0, 32'h00, 1, 32'h00));
      tbl.push_back(mk(0, 0, 32'h0,         0, 32'h00, 1, 32'h00));
      tbl.push_back(mk(0, 0, 32'h0,         1, 32'h14, 1, 32'h04));
      tbl.push_back(mk(0, 0, 32'h0,         0, 32'h00, 1, 32'h08));
      tbl.push_back(mk(0, 0, 32'h0,         1, 32'h18, 1, 32'h0C));
      tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h00, 1, 32'h10));
      tbl.push_back(mk(0, 0, 32'h0,         1, 32'h04, 0, 32'h10));
      tbl.push_back(mk(0, 0, 32'h0,         0, 32'h00, 0, 32'h10));
      tbl.push_back(mk(0, 0, 32'h0,         1, 32'h08, 0, 32'h10));
      tbl.push_back(mk(0, 0, 32'h0,         0, 32'h00, 1, 32'h04));

      tick(-1);
      tick(-1);
      Reset = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         Stall = tbl[i].stall; Branch = tbl[i].branch; BranchOffset = tbl[i].boff;
         tick(i);
      end
      Stall = 1'b0; Branch = 1'b0; BranchOffset = '0;

      // Far branch into the F region, then Branch and Jump together: jump wins.
      wait_valid("far");
      branch_to(32'hF000_0008);
      wait_req("far", 32'hF000_0008);
      wait_valid("far target");
      chk("far inst_pc", InstPC, 32'hF000_0008);
      chk("far inst", Inst, mem_word(32'hF000_0008));
      Jump = 1'b1; Branch = 1'b1; JumpAddress = 26'h000_0040; BranchOffset = 32'h10;
      tick(-1);
      Jump = 1'b0; Branch = 1'b0;
      wait_req("jump", 32'hF000_0100);
      wait_valid("jump target");
      chk("jump inst_pc", InstPC, 32'hF000_0100);

      // Redirect while a 2-cycle response is still in flight: stale word must be discarded.
      fixed_lat = 2;
      n = 0;
      while (!(InstValid === 1'b1 && pend && MemValid === 1'b0) && n < 60) begin tick(-1); n++; end
      chk("drop setup", 32'(InstValid === 1'b1 && pend && MemValid === 1'b0), 32'd1);
      branch_to(32'h0000_0200);
      #1;
      chk("drop no req", 32'(MemReq), 32'd0);
      chk("drop bubble", 32'(InstValid), 32'd0);
      wait_req("drop", 32'h0000_0200);
      wait_valid("drop target");
      chk("drop inst_pc", InstPC, 32'h0000_0200);
      chk("drop inst", Inst, mem_word(32'h0000_0200));

      // Asynchronous reset while a request is outstanding.
      fixed_lat = 3;
      n = 0;
      while (!(pend && MemValid === 1'b0) && n < 60) begin tick(-1); n++; end
      Reset = 1'b1;
      #1;
      chk("rst mem_req", 32'(MemReq), 32'd0);
      chk("rst valid", 32'(InstValid), 32'd0);
      chk("rst inst", Inst, 32'h0);
      chk("rst inst_pc", InstPC, 32'h0);
      tick(-1);
      tick(-1);
      fixed_lat = 1;
      Reset = 1'b0;
      wait_req("rst refetch", 32'h0);
      wait_valid("rst first");
      chk("rst first inst_pc", InstPC, 32'h0);
      chk("rst first inst", Inst, 32'h2001_0005);

      // Random traffic against the model.
      rand_lat = 1'b1;
      spur_en  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         Stall        = ($urandom_range(0, 99) < 25);
         Branch       = ($urandom_range(0, 99) < 8);
         Jump         = ($urandom_range(0, 99) < 4);
         BranchOffset = 32'($urandom_range(0, 63)) - 32'd32;
         JumpAddress  = 26'($urandom);
         MemReady     = ($urandom_range(0, 99) < 75);
         tick(-1);
      end
      Branch = 1'b0; Jump = 1'b0; Stall = 1'b0; MemReady = 1'b1;
      tick(-1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
